matrix_2x2: RTL and testbench
=============================

# matrix_2x2

Sequential 2x2 matrix multiplier: computes C = A × B for two 2x2 matrices of 8-bit unsigned elements, each packed into a 32-bit word. A single shared dot-product unit computes one result element per cycle. The full result is published atomically on a 32-bit output. It runs free-running and back-to-back: it continuously samples its operand inputs, computes, and refreshes the output.

## Interface

No parameters. Element width is fixed at 8 bits; matrix size is fixed at 2x2.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- a  input  32  matrix A, row-major packed: a[31:24]=a11, a[23:16]=a12, a[15:8]=a21, a[7:0]=a22.
- b  input  32  matrix B, same packing as a (b11, b12, b21, b22).
- res  output  32  result C, same packing (c11 in res[31:24] … c22 in res[7:0]); registered.

## Operation

- All elements are unsigned 8-bit.
- cij = ai1·b1j + ai2·b2j.
  - c11 = a11·b11 + a12·b21
  - c12 = a11·b12 + a12·b22
  - c21 = a21·b11 + a22·b21
  - c22 = a21·b12 + a22·b22
- Width rule: products are 16 bits and the sum is 17 bits. The stored element is the sum truncated to bits [7:0] (modulo 256). No saturation, no overflow flag.
- Internal registers:
  - operand registers A_r, B_r (32 bits each)
  - partial-result registers t11, t12, t21 (8 bits each)
  - state register
  - output register res
- State machine, 5 states, one per cycle, unconditional transitions:
  - LOAD: A_r<=a, B_r<=b; next C11.
  - C11: t11<=c11 computed from A_r, B_r; next C12.
  - C12: t12<=c12; next C21.
  - C21: t21<=c21; next C22.
  - C22: res<={t11, t12, t21, c22} in a single write; next LOAD.
- One shared datapath: two 8x8 multipliers and one adder, with operands muxed by state.
- a/b changes between LOAD edges are ignored until the next LOAD.
- res is only ever written in C22, so it never shows a mix of old and new elements.

## Timing

- Reset (rst=0): immediately, without waiting for clk, state=LOAD and A_r, B_r, t11, t12, t21 and res are all 0. These hold while rst=0.
- The first rising edge with rst=1 executes LOAD.
- Latency: operands sampled at edge N appear on res after edge N+4. res holds that value for exactly 5 cycles.
- Throughput: one result per 5 cycles. Samples occur at edges N, N+5, N+10, …
- Reset mid-pass: res goes to 0 immediately and the pass in progress is discarded. Operation restarts at LOAD on the first edge after release.
- If rst rises coincident with a clock edge, that edge is not guaranteed to execute LOAD. Benches release reset away from the active edge.

## Test plan

1. **Reset hold.** rst=0 for 5 cycles with arbitrary a/b -> res=0x00000000 throughout. Drop rst to 0 asynchronously mid-cycle -> res goes to 0 before the next edge.
2. **Basic product.** Release rst with a=0x01020304 and b=0x05060708 held -> res=0x13162B32 (19, 22, 43, 50) after the 5th edge following release. The value is stable for 5 cycles and re-written identically on every pass.
3. **Identity.** a=0x01000001 (I), b=0xDEADBEEF -> res=0xDEADBEEF. With a and b swapped -> res=0xDEADBEEF.
4. **Overflow/truncation.** a=b=0xFFFFFFFF -> each element is 255·255·2=130050, mod 256 = 2, so res=0x02020202. a=b=0x10101010 -> each element is 512 mod 256 = 0, so res=0x00000000.
5. **Mid-pass input change.**
   - Sample a=0x01020304, b=0x05060708 at LOAD.
   - During C12, change a to 0x01000001.
   - Required: res=0x13162B32 at the end of that pass, then res=0x05060708 at the end of the next pass.
6. **Reset mid-pass.** Assert rst=0 during state C21 of a pass computing 0x13162B32 (previous res=0x13162B32) -> res=0 immediately. After release, the first valid result appears 5 edges later.

Source files
------------

// File: rtl/matrix_2x2.sv
// Sequential 2x2 unsigned 8-bit matrix multiplier. It uses one shared dot-product
// unit, produces one element per cycle, and publishes the result every 5 cycles.
module matrix_2x2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res
);

  typedef enum logic [2:0] {LOAD, C11, C12, C21, C22} state_t;

  state_t      state_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [7:0]  t11_reg;
  logic [7:0]  t12_reg;
  logic [7:0]  t21_reg;

  logic        row2;
  logic        col2;
  logic [7:0]  x0, x1, y0, y1;
  logic [7:0]  dot;

  // Row 2 of A feeds C21/C22. Column 2 of B feeds C12/C22.
  always_comb begin
    row2 = (state_reg == C21) || (state_reg == C22);
    col2 = (state_reg == C12) || (state_reg == C22);
    x0   = row2 ? a_reg[15:8] : a_reg[31:24];
    x1   = row2 ? a_reg[7:0]  : a_reg[23:16];
    y0   = col2 ? b_reg[23:16] : b_reg[31:24];
    y1   = col2 ? b_reg[7:0]   : b_reg[15:8];
  end

  // An 8-bit result context keeps only the low byte of the sum of products.
  // This equals the 17-bit sum taken modulo 256.
  assign dot = x0 * y0 + x1 * y1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LOAD;
      a_reg     <= '0;
      b_reg     <= '0;
      t11_reg   <= '0;
      t12_reg   <= '0;
      t21_reg   <= '0;
      res       <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          a_reg     <= a;
          b_reg     <= b;
          state_reg <= C11;
        end
        C11: begin
          t11_reg   <= dot;
          state_reg <= C12;
        end
        C12: begin
          t12_reg   <= dot;
          state_reg <= C21;
        end
        C21: begin
          t21_reg   <= dot;
          state_reg <= C22;
        end
        C22: begin
          res       <= {t11_reg, t12_reg, t21_reg, dot};
          state_reg <= LOAD;
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_2x2.sv
// Directed bench for matrix_2x2 with hand-computed expected results.
module tb_matrix_2x2;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;

  int checks   = 0;
  int failures = 0;

  matrix_2x2 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .res (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset with the operands already applied, then release at a falling edge.
  // The next rising edge performs LOAD.
  task start(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    rst = 1'b0;
    a   = av;
    b   = bv;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task test_reset;
    @(negedge clk);
    rst = 1'b0;
    a   = 32'h01020304;
    b   = 32'h05060708;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      checks++;
      if (res !== 32'h0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: res=%h expected=%h", i, res, 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    edges(5);
    checks++;
    if (res !== 32'h13162B32) begin
      failures++;
      $display("FAIL reset_prefill: res=%h expected=%h", res, 32'h13162B32);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (res !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: res=%h expected=%h", res, 32'h0);
    end
    $display("test_reset done");
  endtask

  task test_basic;
    start(32'h01020304, 32'h05060708);
    edges(4);
    checks++;
    if (res !== 32'h0) begin
      failures++;
      $display("FAIL basic_latency: res=%h expected=%h", res, 32'h0);
    end
    edges(1);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (res !== 32'h13162B32) begin
        failures++;
        $display("FAIL basic_hold cycle %0d: res=%h expected=%h", i, res, 32'h13162B32);
      end
      edges(1);
    end
    $display("test_basic done res=%h", res);
  endtask

  task test_identity;
    start(32'h01000001, 32'hDEADBEEF);
    edges(5);
    checks++;
    if (res !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL identity_left: res=%h expected=%h", res, 32'hDEADBEEF);
    end
    // Swap the operands back-to-back. The next LOAD samples the swapped operands.
    a = 32'hDEADBEEF;
    b = 32'h01000001;
    edges(5);
    checks++;
    if (res !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL identity_right: res=%h expected=%h", res, 32'hDEADBEEF);
    end
    a = 32'h01020304;
    b = 32'h01000001;
    edges(5);
    checks++;
    if (res !== 32'h01020304) begin
      failures++;
      $display("FAIL identity_b: res=%h expected=%h", res, 32'h01020304);
    end
    $display("test_identity done res=%h", res);
  endtask

  task test_overflow;
    start(32'hFFFFFFFF, 32'hFFFFFFFF);
    edges(5);
    checks++;
    if (res !== 32'h02020202) begin
      failures++;
      $display("FAIL overflow_ff: res=%h expected=%h", res, 32'h02020202);
    end
    a = 32'h10101010;
    b = 32'h10101010;
    edges(5);
    checks++;
    if (res !== 32'h00000000) begin
      failures++;
      $display("FAIL overflow_10: res=%h expected=%h", res, 32'h0);
    end
    a = 32'h80FF0201;
    b = 32'h0302FF10;
    // c11 = 0x80*3 + 0xFF*0xFF = 384 + 65025 = 65409 -> 0x81
    // c12 = 0x80*2 + 0xFF*0x10 = 256 + 4080 = 4336 -> 0xF0
    // c21 = 2*3 + 1*0xFF = 261 -> 0x05
    // c22 = 2*2 + 1*0x10 = 20 -> 0x14
    edges(5);
    checks++;
    if (res !== 32'h81F00514) begin
      failures++;
      $display("FAIL overflow_mix: res=%h expected=%h", res, 32'h81F00514);
    end
    $display("test_overflow done res=%h", res);
  endtask

  task test_midpass;
    start(32'h01020304, 32'h05060708);
    edges(2);
    a = 32'h01000001;
    edges(3);
    checks++;
    if (res !== 32'h13162B32) begin
      failures++;
      $display("FAIL midpass_first: res=%h expected=%h", res, 32'h13162B32);
    end
    edges(4);
    checks++;
    if (res !== 32'h13162B32) begin
      failures++;
      $display("FAIL midpass_hold: res=%h expected=%h", res, 32'h13162B32);
    end
    edges(1);
    checks++;
    if (res !== 32'h05060708) begin
      failures++;
      $display("FAIL midpass_second: res=%h expected=%h", res, 32'h05060708);
    end
    $display("test_midpass done res=%h", res);
  endtask

  task test_reset_midpass;
    start(32'h01020304, 32'h05060708);
    // After 8 edges the pass has reached state C21.
    edges(8);
    checks++;
    if (res !== 32'h13162B32) begin
      failures++;
      $display("FAIL rmid_before: res=%h expected=%h", res, 32'h13162B32);
    end
    #2;
    rst = 1'b0;
    a   = 32'h01000001;
    b   = 32'hDEADBEEF;
    #1;
    checks++;
    if (res !== 32'h0) begin
      failures++;
      $display("FAIL rmid_async: res=%h expected=%h", res, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    edges(4);
    checks++;
    if (res !== 32'h0) begin
      failures++;
      $display("FAIL rmid_latency: res=%h expected=%h", res, 32'h0);
    end
    edges(1);
    checks++;
    if (res !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rmid_result: res=%h expected=%h", res, 32'hDEADBEEF);
    end
    $display("test_reset_midpass done res=%h", res);
  endtask

  initial begin
    rst = 1'b0;
    a   = 32'h0;
    b   = 32'h0;
    #3;
    checks++;
    if (res !== 32'h0) begin
      failures++;
      $display("FAIL reset_initial: res=%h expected=%h", res, 32'h0);
    end
    test_reset();
    test_basic();
    test_identity();
    test_overflow();
    test_midpass();
    test_reset_midpass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
